// File: rtl/uart_tx_word_scheduler_pkg.sv
// Shared definitions for the UART TX word scheduler.
// - state_t : FSM state encoding (3-bit).
// - nbytes_of() : bytes per word for a given word width. The byte counter
//   width CNT_W must satisfy 2**CNT_W >= nbytes_of(N).
package uart_tx_word_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

  // Number of bytes in an n-bit word (n is a multiple of 8).
  function automatic int nbytes_of(input int n);
    return n / 8;
  endfunction

endpackage

// File: rtl/uart_tx_word_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_req0_valid/1      request lines
//   i_enable            grants are only issued while high
//   i_ptr_upd           load the priority pointer with i_ptr_next
//   i_ptr_next          next priority holder
//   o_gnt0/o_gnt1       one-hot (or zero) grant
module rr_arbiter2
  import uart_tx_word_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_req0_valid,
  input  logic i_req1_valid,
  input  logic i_enable,
  input  logic i_ptr_upd,
  input  logic i_ptr_next,
  output logic o_gnt0,
  output logic o_gnt1
);

  logic r_ptr;

  // Priority pointer: which requester wins when both are valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (i_ptr_upd) begin
      r_ptr <= i_ptr_next;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Grant: a lone requester always wins; on contention r_ptr decides.
  always_comb begin
    o_gnt0 = i_enable & i_req0_valid & (~i_req1_valid | ~r_ptr);
    o_gnt1 = i_enable & i_req1_valid & (~i_req0_valid |  r_ptr);
  end

endmodule

// File: rtl/uart_tx_word_scheduler.sv
// Shares one UART byte transmitter between two N-bit word producers.
// Words are granted round-robin and sent MSB byte first; each byte waits
// for the transmitter busy flag to rise and fall before the next is issued.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   i_reqX_valid/i_reqX_data   word offer from requester X
//   o_reqX_ready               one-cycle pulse: word X was captured
//   i_is_transmitting          UART TX busy flag
//   o_tx_byte/o_tx_valid       byte and one-cycle strobe to the UART
//   o_busy                     word in flight
//   o_grant_id                 owner of the current word
module uart_tx_word_scheduler
  import uart_tx_word_scheduler_pkg::*;
#(
  parameter int N             = 16,
  parameter int CNT_W         = 2,
  parameter int START_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_req0_valid,
  input  logic [N-1:0] i_req0_data,
  output logic         o_req0_ready,
  input  logic         i_req1_valid,
  input  logic [N-1:0] i_req1_data,
  output logic         o_req1_ready,
  input  logic         i_is_transmitting,
  output logic [7:0]   o_tx_byte,
  output logic         o_tx_valid,
  output logic         o_busy,
  output logic         o_grant_id
);

  localparam int NBYTES = nbytes_of(N);
  localparam int TO_W   = (START_TIMEOUT < 1) ? 1 : $clog2(START_TIMEOUT + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N-1:0]     r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;
  logic [TO_W-1:0]  r_to;
  logic             r_tx_valid;
  logic [7:0]       r_tx_byte;
  logic             r_ready0;
  logic             r_ready1;
  logic             r_busy;
  logic             r_grant;

  logic w_enable;
  logic w_gnt0;
  logic w_gnt1;
  logic w_capture;
  logic w_issue;
  logic w_accept;
  logic w_finish;
  logic w_done;

  // Never start a word while the UART is still busy with someone else's byte.
  assign w_enable = (r_state == ST_IDLE) && !i_is_transmitting;

  rr_arbiter2 u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req0_valid (i_req0_valid),
    .i_req1_valid (i_req1_valid),
    .i_enable     (w_enable),
    .i_ptr_upd    (w_done),
    .i_ptr_next   (~r_grant),
    .o_gnt0       (w_gnt0),
    .o_gnt1       (w_gnt1)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and per-cycle action strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_issue     = 1'b0;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt0 || w_gnt1) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_issue     = 1'b1;
        w_state_nxt = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        // A rise coinciding with the strobe is seen here one cycle later,
        // so it counts as a start rather than a timeout.
        if (i_is_transmitting) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_to == TO_W'(START_TIMEOUT)) begin
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_WAIT_START;
        end
      end
      ST_WAIT_DONE: begin
        if (!i_is_transmitting) begin
          if (r_last) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_ISSUE;
          end
        end else begin
          w_state_nxt = ST_WAIT_DONE;
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: word capture, byte shifting, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_cnt      <= '0;
      r_last     <= 1'b0;
      r_to       <= '0;
      r_tx_valid <= 1'b0;
      r_tx_byte  <= 8'h00;
      r_ready0   <= 1'b0;
      r_ready1   <= 1'b0;
      r_busy     <= 1'b0;
      r_grant    <= 1'b0;
    end else begin
      r_ready0   <= w_capture & w_gnt0;
      r_ready1   <= w_capture & w_gnt1;
      r_tx_valid <= w_issue;
      if (w_issue) begin
        r_tx_byte <= r_shift[N-1 -: 8];
      end
      if (w_capture) begin
        r_shift <= w_gnt0 ? i_req0_data : i_req1_data;
        r_grant <= w_gnt1;
        r_busy  <= 1'b1;
        r_cnt   <= '0;
        r_last  <= 1'b0;
      end else if (w_accept) begin
        // r_last is latched here so the counter may equal 2**CNT_W at the end.
        r_shift <= r_shift << 8;
        r_cnt   <= r_cnt + 1'b1;
        r_last  <= (r_cnt == CNT_W'(NBYTES - 1));
      end
      if (w_issue) begin
        r_to <= '0;
      end else if (r_state == ST_WAIT_START) begin
        r_to <= r_to + 1'b1;
      end
      if (w_finish) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_req0_ready = r_ready0;
  assign o_req1_ready = r_ready1;
  assign o_tx_byte    = r_tx_byte;
  assign o_tx_valid   = r_tx_valid;
  assign o_busy       = r_busy;
  assign o_grant_id   = r_grant;

endmodule

// File: tb/tb_uart_tx_word_scheduler.sv
// Directed bench for uart_tx_word_scheduler (N=16, START_TIMEOUT=15).
module tb_uart_tx_word_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0_valid = 1'b0;
  logic [15:0] req0_data = 16'h0000;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [15:0] req1_data = 16'h0000;
  logic        req1_ready;
  logic        is_tx;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        busy;
  logic        grant_id;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Producers: word tables written by the stimulus, read pointers by the driver.
  logic [15:0] w0 [0:15];
  logic [15:0] w1 [0:15];
  int w0_cnt = 0, w1_cnt = 0, rd0 = 0, rd1 = 0;

  // Logs written only by the monitor.
  logic [7:0] tx_log  [0:63];
  int         tx_time [0:63];
  int         tx_n = 0;
  logic       gid_log [0:31];
  int         gid_n = 0;
  int         n_rdy0 = 0, n_rdy1 = 0;
  int         rdy_time = 0;

  // UART model.
  logic       m_is_tx = 1'b0;
  logic       force_tx = 1'b0;
  int         hold = 0;
  bit         pend = 1'b0;
  logic [7:0] ign_byte = 8'h5A;
  int         ign_req = 0, ign_done = 0;

  assign is_tx = m_is_tx | force_tx;

  uart_tx_word_scheduler #(.N(16), .CNT_W(2), .START_TIMEOUT(15)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_req0_valid      (req0_valid),
    .i_req0_data       (req0_data),
    .o_req0_ready      (req0_ready),
    .i_req1_valid      (req1_valid),
    .i_req1_data       (req1_data),
    .o_req1_ready      (req1_ready),
    .i_is_transmitting (is_tx),
    .o_tx_byte         (tx_byte),
    .o_tx_valid        (tx_valid),
    .o_busy            (busy),
    .o_grant_id        (grant_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor + requester driver: log strobes, pop words on ready, present next word.
  always @(negedge clk) begin
    if (tx_valid) begin
      tx_log[tx_n]  = tx_byte;
      tx_time[tx_n] = cyc;
      tx_n++;
    end
    if (req0_ready) begin
      rd0++; n_rdy0++; rdy_time = cyc;
      gid_log[gid_n] = grant_id; gid_n++;
    end
    if (req1_ready) begin
      rd1++; n_rdy1++; rdy_time = cyc;
      gid_log[gid_n] = grant_id; gid_n++;
    end
    req0_valid = (rd0 < w0_cnt);
    req0_data  = (rd0 < w0_cnt) ? w0[rd0] : 16'h0000;
    req1_valid = (rd1 < w1_cnt);
    req1_data  = (rd1 < w1_cnt) ? w1[rd1] : 16'h0000;
  end

  // UART model: busy for 4 cycles starting one cycle after each accepted strobe.
  always @(negedge clk) begin
    if (hold > 0) begin
      hold--;
      if (hold == 0) m_is_tx = 1'b0;
    end else if (pend) begin
      pend    = 1'b0;
      m_is_tx = 1'b1;
      hold    = 4;
    end
    if (tx_valid) begin
      if (ign_done < ign_req && tx_byte == ign_byte) ign_done++;
      else pend = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push0(input logic [15:0] d);
    w0[w0_cnt] = d; w0_cnt++;
  endtask

  task automatic push1(input logic [15:0] d);
    w1[w1_cnt] = d; w1_cnt++;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k = 0;
    while (k < max && !(rd0 == w0_cnt && rd1 == w1_cnt && !busy && !is_tx)) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(k < max), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int b;
    int r0;
    int g;
    int k;

    // Reset state.
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_byte",  32'(tx_byte),  32'd0);
    check("rst_ready0",   32'(req0_ready), 32'd0);
    check("rst_ready1",   32'(req1_ready), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_grant",    32'(grant_id), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single word from requester 0.
    b = tx_n; r0 = n_rdy0;
    push0(16'hA55A);
    wait_idle("t1_idle", 300);
    check("t1_count", 32'(tx_n - b), 32'd2);
    check("t1_byte0", 32'(tx_log[b]),   32'hA5);
    check("t1_byte1", 32'(tx_log[b+1]), 32'h5A);
    check("t1_ready", 32'(n_rdy0 - r0), 32'd1);
    check("t1_lat",   32'(tx_time[b] - rdy_time), 32'd1);
    check("t1_gap",   32'(tx_time[b+1] - tx_time[b]), 32'd7);
    check("t1_busy",  32'(busy), 32'd0);

    // 2: both valid out of reset; requester 0 first.
    pulse_reset();
    b = tx_n; g = gid_n;
    push0(16'h1111);
    push1(16'h2222);
    wait_idle("t2_idle", 400);
    check("t2_count", 32'(tx_n - b), 32'd4);
    check("t2_b0", 32'(tx_log[b]),   32'h11);
    check("t2_b1", 32'(tx_log[b+1]), 32'h11);
    check("t2_b2", 32'(tx_log[b+2]), 32'h22);
    check("t2_b3", 32'(tx_log[b+3]), 32'h22);
    check("t2_gid0", 32'(gid_log[g]),   32'd0);
    check("t2_gid1", 32'(gid_log[g+1]), 32'd1);

    // 3: both continuously valid for four words; grants alternate.
    b = tx_n; g = gid_n;
    push0(16'h0A0B); push0(16'h0C0D);
    push1(16'h1A1B); push1(16'h1C1D);
    wait_idle("t3_idle", 800);
    check("t3_grants", 32'(gid_n - g), 32'd4);
    check("t3_gid0", 32'(gid_log[g]),   32'd0);
    check("t3_gid1", 32'(gid_log[g+1]), 32'd1);
    check("t3_gid2", 32'(gid_log[g+2]), 32'd0);
    check("t3_gid3", 32'(gid_log[g+3]), 32'd1);
    check("t3_b2", 32'(tx_log[b+2]), 32'h1A);
    check("t3_b5", 32'(tx_log[b+5]), 32'h0D);
    check("t3_b7", 32'(tx_log[b+7]), 32'h1D);

    // 4: first strobe for 0x5A ignored; byte re-issued after timeout.
    b = tx_n; r0 = n_rdy0;
    ign_req = 1;
    push0(16'hA55A);
    wait_idle("t4_idle", 400);
    check("t4_count", 32'(tx_n - b), 32'd3);
    check("t4_b0", 32'(tx_log[b]),   32'hA5);
    check("t4_b1", 32'(tx_log[b+1]), 32'h5A);
    check("t4_b2", 32'(tx_log[b+2]), 32'h5A);
    check("t4_reissue", 32'(tx_time[b+2] - tx_time[b+1]), 32'd17);
    check("t4_ready", 32'(n_rdy0 - r0), 32'd1);

    // 5: reset while waiting for byte 1 to finish.
    b = tx_n;
    push0(16'h1234);
    k = 0;
    while (k < 200 && tx_n == b) begin @(negedge clk); k++; end
    check("t5_first_strobe", 32'(k < 200), 32'd1);
    repeat (3) @(negedge clk);
    check("t5_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(tx_valid), 32'd0);
    check("t5_rst_busy",  32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    b = tx_n; g = gid_n;
    push1(16'hBEEF);
    wait_idle("t5_idle", 400);
    check("t5_count", 32'(tx_n - b), 32'd2);
    check("t5_b0", 32'(tx_log[b]),   32'hBE);
    check("t5_b1", 32'(tx_log[b+1]), 32'hEF);
    check("t5_gid", 32'(gid_log[g]), 32'd1);

    // 6: UART busy while a request waits in IDLE.
    @(negedge clk);
    force_tx = 1'b1;
    b = tx_n;
    push0(16'h3C3C);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_hold_ready", 32'(req0_ready), 32'd0);
    end
    check("t6_hold_busy", 32'(busy), 32'd0);
    force_tx = 1'b0;
    @(posedge clk);
    #1;
    check("t6_ready_next", 32'(req0_ready), 32'd1);
    wait_idle("t6_idle", 300);
    check("t6_count", 32'(tx_n - b), 32'd2);
    check("t6_b0", 32'(tx_log[b]), 32'h3C);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_word_scheduler.md
Name: uart_tx_word_scheduler

Overview:
Shares the single UART byte transmitter between two word producers: the RSA result path (requester 0) and the debug/status path (requester 1). Each requester offers an N-bit word. The block grants one word at a time with round-robin arbitration and sends it MSB byte first. Every byte is paced by the transmitter's is_transmitting flag, so a word is never interrupted. The block sits between the datapath result registers and the UART TX.

Parameters:
N, 16, word width in bits; must be a multiple of 8 and at least 8
NBYTES, N/8, bytes per word (derived localparam, not overridable)
CNT_W, 2, width of the byte counter; must satisfy 2^CNT_W >= NBYTES
START_TIMEOUT, 15, cycles to wait for is_transmitting to rise after tx_valid before the byte is re-issued

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a word
req0_data  input  N  requester 0 word
req0_ready  output  1  one-cycle pulse: req0_data is captured this cycle
req1_valid  input  1  requester 1 has a word
req1_data  input  N  requester 1 word
req1_ready  output  1  one-cycle pulse: req1_data is captured this cycle
is_transmitting  input  1  UART TX busy flag
tx_byte  output  8  byte to transmit
tx_valid  output  1  one-cycle strobe: tx_byte is valid
busy  output  1  high from word capture until the last byte completes
grant_id  output  1  requester that owns the current word

Behaviour:
- Reset values (asynchronous): state=IDLE, tx_valid=0, tx_byte=0, req0_ready=0, req1_ready=0, busy=0, grant_id=0, rr_ptr=0, byte count=0, timeout counter=0.
- rr_ptr holds the requester that has priority. It toggles only when a word completes in DONE.
- IDLE:
  - If only one valid is high, grant that requester. If both are high, grant rr_ptr.
  - On grant, in the same cycle: assert the granted reqX_ready; capture the word into the shift register; set grant_id; set busy=1; clear the byte count; go to ISSUE.
  - If is_transmitting=1 while in IDLE, stay in IDLE and grant nothing.
- ISSUE:
  - Drive tx_byte = shift[N-1:N-8] and assert tx_valid=1 for exactly one cycle.
  - Clear the timeout counter and go to WAIT_START.
- WAIT_START: wait for is_transmitting=1.
  - When seen: shift the register left by 8, increment the byte count, go to WAIT_DONE.
  - If the timeout counter reaches START_TIMEOUT first, go back to ISSUE and re-send the same byte (no shift, no count change).
- WAIT_DONE: wait for is_transmitting=0.
  - If the byte count equals NBYTES, go to DONE.
  - Otherwise go to ISSUE.
- DONE (one cycle): busy=0, rr_ptr = ~grant_id, go to IDLE.
- Latency:
  - Capture to first tx_valid: 1 cycle.
  - Falling edge of is_transmitting to next tx_valid: 1 cycle.
- Ready/valid rules:
  - A requester must hold reqX_valid and reqX_data stable until its reqX_ready pulse.
  - At most one ready pulses per word.
  - Ready is never asserted outside IDLE.
- Boundary cases:
  - valid is dropped before grant: nothing is captured; no ready pulse.
  - is_transmitting rises in the same cycle tx_valid is asserted: treat it as the next cycle's WAIT_START condition; no re-issue.
  - N=8: single byte per word, so the FSM goes ISSUE → WAIT_START → WAIT_DONE → DONE.
  - Byte count must not wrap before it reaches NBYTES; the CNT_W constraint guarantees this.
- Reset mid-word: all outputs return to reset values immediately and the partial word is discarded. The requester is not re-notified, because its ready already pulsed.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE, ST_ISSUE, ST_WAIT_START, ST_WAIT_DONE, ST_DONE (3-bit)
  - the NBYTES/CNT_W derivation rule
- One natural sub-module: rr_arbiter2. It is combinational grant logic plus the rr_ptr flop. Inputs: req0_valid, req1_valid, ptr, enable. Outputs: gnt0, gnt1.
- The FSM, shift register and timeout counter stay in the top module.

Test Plan:
- N=16, req0 0xA55A alone; UART model holds is_transmitting high for 4 cycles, starting 1 cycle after each tx_valid → tx_byte 0xA5 then 0x5A; exactly 2 tx_valid pulses; one req0_ready pulse; busy falls after the second byte.
- req0=0x1111 and req1=0x2222 asserted together out of reset → req0 served first (rr_ptr=0) with grant_id=0, then req1 with grant_id=1; byte stream 11 11 22 22.
- Both requesters held continuously valid for 4 words → grants alternate 0,1,0,1.
- UART model ignores the first tx_valid for 0x5A → tx_valid re-issued START_TIMEOUT+2 cycles later with the same byte 0x5A; no shift; word still completes with 2 accepted bytes.
- rst_n pulsed low while in WAIT_DONE of byte 1 → tx_valid=0 and busy=0 immediately; after release, a new req1 word 0xBEEF is sent cleanly as BE EF.
- is_transmitting held high while req0_valid=1 in IDLE → no req0_ready until is_transmitting falls; ready is then asserted the next cycle.
